// File: rtl/reveal_engine.sv
// reveal_engine
//   Turns accepted cursor clicks into the revealed-cell bitmap and count that
//   the game-state checker consumes. A click on a zero cell starts a flood
//   fill. The fill scans one cell per cycle in row-major order and repeats
//   whole passes until a pass reveals nothing new.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   map_flat[255:0]   4-bit value per cell: 0-8 neighbour mines, >=9 mine
//   click             one-cycle reveal request at (cur_row, cur_col)
//   cur_row, cur_col  cursor position, sampled with click
//   dead, won         game-over flags; while either is high, clicks are ignored
//   clicked_flat[63:0] revealed bitmap, bit r*8+c
//   num_clicked[5:0]  revealed count, saturating at 63
//   busy              high while a flood fill runs
//   reveal_done       one-cycle pulse when an accepted click is complete
module reveal_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] map_flat,
  input  logic         click,
  input  logic [2:0]   cur_row,
  input  logic [2:0]   cur_col,
  input  logic         dead,
  input  logic         won,
  output logic [63:0]  clicked_flat,
  output logic [5:0]   num_clicked,
  output logic         busy,
  output logic         reveal_done
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 32'd1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 32'd1);
  localparam logic [5:0] LAST_IDX = 6'(ROWS * COLS - 32'd1);
  localparam logic [5:0] ROW_STEP = 6'(COLS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        changed_q, changed_d;
  logic [63:0] clicked_q, clicked_d;
  logic [5:0]  num_q, num_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [5:0]  cur_idx_s;
  logic [2:0]  scan_row_s;
  logic [2:0]  scan_col_s;
  logic        qualify_s;
  logic        accept_s;
  logic        changed_now_s;
  logic [5:0]  nbr_idx_s [8];
  logic [7:0]  nbr_ok_s;
  logic [63:0] nbr_mask_s;
  logic [63:0] new_bits_s;

  function automatic logic [3:0] cell_val(input logic [255:0] map, input logic [5:0] idx);
    cell_val = map[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] bits);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + {6'd0, bits[i]};
    end
    return cnt;
  endfunction

  function automatic logic [5:0] sat_add(input logic [5:0] base, input logic [6:0] inc);
    logic [7:0] sum;
    sum = {2'b00, base} + {1'b0, inc};
    if (sum > 8'd63) begin
      sat_add = 6'd63;
    end else begin
      sat_add = sum[5:0];
    end
  endfunction

  assign cur_idx_s  = {cur_row, cur_col};
  assign scan_row_s = idx_q[5:3];
  assign scan_col_s = idx_q[2:0];

  // Neighbour candidates of the scanned cell; the edge flags stop row wrap-around.
  always_comb begin
    nbr_idx_s[0] = idx_q - ROW_STEP - 6'd1;
    nbr_idx_s[1] = idx_q - ROW_STEP;
    nbr_idx_s[2] = idx_q - ROW_STEP + 6'd1;
    nbr_idx_s[3] = idx_q - 6'd1;
    nbr_idx_s[4] = idx_q + 6'd1;
    nbr_idx_s[5] = idx_q + ROW_STEP - 6'd1;
    nbr_idx_s[6] = idx_q + ROW_STEP;
    nbr_idx_s[7] = idx_q + ROW_STEP + 6'd1;
    nbr_ok_s[0] = (scan_row_s != 3'd0) && (scan_col_s != 3'd0);
    nbr_ok_s[1] = (scan_row_s != 3'd0);
    nbr_ok_s[2] = (scan_row_s != 3'd0) && (scan_col_s != LAST_COL);
    nbr_ok_s[3] = (scan_col_s != 3'd0);
    nbr_ok_s[4] = (scan_col_s != LAST_COL);
    nbr_ok_s[5] = (scan_row_s != LAST_ROW) && (scan_col_s != 3'd0);
    nbr_ok_s[6] = (scan_row_s != LAST_ROW);
    nbr_ok_s[7] = (scan_row_s != LAST_ROW) && (scan_col_s != LAST_COL);
  end

  // Mask of in-bounds non-mine neighbours, and the bits they would newly reveal.
  always_comb begin
    nbr_mask_s = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (nbr_ok_s[k] && (cell_val(map_flat, nbr_idx_s[k]) < 4'd9)) begin
        nbr_mask_s[nbr_idx_s[k]] = 1'b1;
      end else begin
        nbr_mask_s = nbr_mask_s;
      end
    end
    qualify_s = clicked_q[idx_q] && (cell_val(map_flat, idx_q) == 4'd0);
    if (qualify_s) begin
      new_bits_s = nbr_mask_s & ~clicked_q;
    end else begin
      new_bits_s = 64'd0;
    end
  end

  // Next-state logic for the click/sweep controller.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    changed_d     = changed_q;
    clicked_d     = clicked_q;
    num_d         = num_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    accept_s      = click && !dead && !won && !clicked_q[cur_idx_s];
    changed_now_s = changed_q || (new_bits_s != 64'd0);
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (accept_s) begin
          clicked_d = clicked_q | (64'd1 << cur_idx_s);
          num_d     = sat_add(num_q, 7'd1);
          if (cell_val(map_flat, cur_idx_s) == 4'd0) begin
            state_d   = ST_SWEEP;
            idx_d     = 6'd0;
            changed_d = 1'b0;
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        clicked_d = clicked_q | new_bits_s;
        num_d     = sat_add(num_q, popcount64(new_bits_s));
        if (idx_q == LAST_IDX) begin
          // A change anywhere in the pass, including the last cell, forces another pass.
          if (changed_now_s) begin
            idx_d     = 6'd0;
            changed_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          idx_d     = idx_q + 6'd1;
          changed_d = changed_now_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 6'd0;
      changed_q <= 1'b0;
      clicked_q <= 64'd0;
      num_q     <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      changed_q <= changed_d;
      clicked_q <= clicked_d;
      num_q     <= num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign clicked_flat = clicked_q;
  assign num_clicked  = num_q;
  assign busy         = busy_q;
  assign reveal_done  = done_q;

endmodule

// File: tb/tb_reveal_engine.sv
// Self-checking bench for reveal_engine. A software flood-fill model pushes
// the expected bitmap/count into a scoreboard when a click is driven; entries
// are popped and compared when the DUT pulses reveal_done.
module tb_reveal_engine;

  logic         clk;
  logic         rst;
  logic [255:0] map_flat;
  logic         click;
  logic [2:0]   cur_row;
  logic [2:0]   cur_col;
  logic         dead;
  logic         won;
  logic [63:0]  clicked_flat;
  logic [5:0]   num_clicked;
  logic         busy;
  logic         reveal_done;

  typedef struct packed {
    logic [63:0] bits;
    logic [5:0]  num;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  map_m [64];
  logic [63:0] mdl_clicked;
  int          n_cmp;
  int          n_err;

  reveal_engine #(.ROWS(8), .COLS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .map_flat     (map_flat),
    .click        (click),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .dead         (dead),
    .won          (won),
    .clicked_flat (clicked_flat),
    .num_clicked  (num_clicked),
    .busy         (busy),
    .reveal_done  (reveal_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] sat_pop(input logic [63:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(b[i]);
    if (n > 63) n = 63;
    return 6'(n);
  endfunction

  // Build the map from a mine bitmap, computing neighbour counts.
  task automatic load_map(input logic [63:0] mines, input logic [3:0] mine_val);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(mines[(r + dr) * 8 + c + dc]);
          end
        end
        map_m[r * 8 + c] = mines[r * 8 + c] ? mine_val : 4'(cnt);
      end
    end
    for (int i = 0; i < 64; i++) map_flat[i * 4 +: 4] = map_m[i];
  endtask

  // Software model: reveal target, then grow connected zero regions to a fixed point.
  task automatic model_click(input int r, input int c);
    logic [63:0] b;
    bit grew;
    exp_t e;
    b = mdl_clicked;
    b[r * 8 + c] = 1'b1;
    grew = (map_m[r * 8 + c] == 4'd0);
    while (grew) begin
      grew = 1'b0;
      for (int rr = 0; rr < 8; rr++) begin
        for (int cc = 0; cc < 8; cc++) begin
          if (b[rr * 8 + cc] && map_m[rr * 8 + cc] == 4'd0) begin
            for (int dr = -1; dr <= 1; dr++) begin
              for (int dc = -1; dc <= 1; dc++) begin
                int nr, nc;
                nr = rr + dr;
                nc = cc + dc;
                if ((dr != 0 || dc != 0) && nr >= 0 && nr < 8 && nc >= 0 && nc < 8) begin
                  if (map_m[nr * 8 + nc] < 4'd9 && !b[nr * 8 + nc]) begin
                    b[nr * 8 + nc] = 1'b1;
                    grew = 1'b1;
                  end
                end
              end
            end
          end
        end
      end
    end
    mdl_clicked = b;
    e.bits = b;
    e.num  = sat_pop(b);
    sb_q.push_back(e);
  endtask

  task automatic drive_click(input int r, input int c);
    @(negedge clk);
    cur_row = 3'(r);
    cur_col = 3'(c);
    click   = 1'b1;
    @(negedge clk);
    click   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_clicked = 64'd0;
    sb_q.delete();
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: reveal_done with empty scoreboard, got %h", name, clicked_flat);
    end else begin
      e = sb_q.pop_front();
      if (clicked_flat !== e.bits) begin
        n_err++;
        $display("FAIL %s bits: got %h expected %h", name, clicked_flat, e.bits);
      end
      n_cmp++;
      if (num_clicked !== e.num) begin
        n_err++;
        $display("FAIL %s num: got %0d expected %0d", name, num_clicked, e.num);
      end
    end
  endtask

  // Follows a sweep to completion; optionally pokes an illegal click mid-sweep.
  task automatic wait_sweep(input string name, input bit poke, output int len);
    len = 0;
    while (busy === 1'b1 && len < 4096) begin
      if (poke && len == 10) begin
        cur_row = 3'd6;
        cur_col = 3'd0;
        click   = 1'b1;
      end else begin
        click = 1'b0;
      end
      @(negedge clk);
      len++;
    end
    click = 1'b0;
    n_cmp++;
    if (len >= 4096 || reveal_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s end: busy_len %0d reveal_done %b expected done 1 within bound", name, len, reveal_done);
    end
  endtask

  task automatic click_nonzero(input string name, input int r, input int c);
    model_click(r, c);
    drive_click(r, c);
    n_cmp++;
    if (reveal_done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s timing: done %b busy %b expected done 1 busy 0", name, reveal_done, busy);
    end
    check_pop(name);
  endtask

  task automatic click_ignored(input string name, input int r, input int c);
    bit pulse;
    pulse = 1'b0;
    drive_click(r, c);
    for (int i = 0; i < 4; i++) begin
      if (reveal_done === 1'b1 || busy === 1'b1) pulse = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (pulse || clicked_flat !== mdl_clicked) begin
      n_err++;
      $display("FAIL %s: pulse %b bits %h expected no pulse bits %h", name, pulse, clicked_flat, mdl_clicked);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (clicked_flat !== 64'd0) begin n_err++; $display("FAIL reset_bits: got %h expected 0", clicked_flat); end
    n_cmp++;
    if (num_clicked !== 6'd0) begin n_err++; $display("FAIL reset_num: got %0d expected 0", num_clicked); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (reveal_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", reveal_done); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 64; i++) map_m[i] = 4'd1;
    map_m[63] = 4'd9;
    for (int i = 0; i < 64; i++) map_flat[i * 4 +: 4] = map_m[i];
    click_nonzero("single", 3, 4);
    n_cmp++;
    if (clicked_flat !== 64'h0000_0000_1000_0000 || num_clicked !== 6'd1) begin
      n_err++;
      $display("FAIL single_abs: got %h/%0d expected bit28/1", clicked_flat, num_clicked);
    end
  endtask

  task automatic test_gated();
    click_ignored("repeat", 3, 4);
    dead = 1'b1;
    click_ignored("dead", 0, 0);
    dead = 1'b0;
    won = 1'b1;
    click_ignored("won", 1, 1);
    won = 1'b0;
  endtask

  task automatic test_flood();
    int len;
    do_reset();
    // Row 6 mines at cols 1,4,7 border every row-5 cell; row 7 cols 0-6 mined.
    load_map(64'h7F92_0000_0000_0000, 4'd9);
    model_click(0, 0);
    drive_click(0, 0);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL flood_busy: got %b expected 1", busy); end
    wait_sweep("flood", 1'b1, len);
    check_pop("flood");
    n_cmp++;
    if (clicked_flat !== 64'h0000_FFFF_FFFF_FFFF || num_clicked !== 6'd48) begin
      n_err++;
      $display("FAIL flood_abs: got %h/%0d expected rows0-5/48", clicked_flat, num_clicked);
    end
    n_cmp++;
    if (len != 128 || (len % 64) != 0) begin
      n_err++;
      $display("FAIL flood_len: got %0d expected 128", len);
    end
    click_nonzero("mine", 7, 3);
    n_cmp++;
    if (clicked_flat[59] !== 1'b1 || num_clicked !== 6'd49) begin
      n_err++;
      $display("FAIL mine_abs: got bit %b num %0d expected 1/49", clicked_flat[59], num_clicked);
    end
  endtask

  task automatic test_edge_wrap();
    int len;
    do_reset();
    load_map(64'h2020_2020_2020_2020, 4'd12);
    model_click(0, 0);
    drive_click(0, 0);
    wait_sweep("west", 1'b0, len);
    check_pop("west");
    n_cmp++;
    if (clicked_flat !== 64'h1F1F_1F1F_1F1F_1F1F) begin
      n_err++;
      $display("FAIL west_abs: got %h expected 1f1f1f1f1f1f1f1f", clicked_flat);
    end
    model_click(0, 7);
    drive_click(0, 7);
    wait_sweep("east", 1'b0, len);
    check_pop("east");
    n_cmp++;
    if (clicked_flat !== 64'hDFDF_DFDF_DFDF_DFDF || (len % 64) != 0) begin
      n_err++;
      $display("FAIL east_abs: got %h len %0d expected dfdfdfdfdfdfdfdf", clicked_flat, len);
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    load_map(64'h7F92_0000_0000_0000, 4'd9);
    drive_click(0, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_clicked = 64'd0;
    sb_q.delete();
    n_cmp++;
    if (clicked_flat !== 64'd0 || num_clicked !== 6'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst: got %h/%0d/%b expected 0/0/0", clicked_flat, num_clicked, busy);
    end
    // Issued on the first cycle with rst low.
    model_click(5, 0);
    cur_row = 3'd5;
    cur_col = 3'd0;
    click   = 1'b1;
    @(negedge clk);
    click   = 1'b0;
    n_cmp++;
    if (reveal_done !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_click: done %b expected 1", reveal_done);
    end
    check_pop("midrst_click");
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    click    = 1'b0;
    cur_row  = 3'd0;
    cur_col  = 3'd0;
    dead     = 1'b0;
    won      = 1'b0;
    map_flat = 256'd0;
    mdl_clicked = 64'd0;
    test_reset();
    test_single();
    test_gated();
    test_flood();
    test_edge_wrap();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
